// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: loads a parallel pattern and shifts it out LSB first with valid/index/done strobes.
// Defining PATTERN_REPEAT_EN makes the pattern repeat until STOP is seen at a last-bit edge.
module serial_pattern_tx #(
  parameter int WIDTH = 20,
  parameter int IDXW  = 5
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  input  logic [WIDTH-1:0] DATA,
  input  logic             STOP,
  output logic             x,
  output logic             X_VALID,
  output logic [IDXW-1:0]  BIT_IDX,
  output logic             DONE,
  output logic [1:0]       S
);
`ifdef PATTERN_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] shreg, hold, shreg_nx, hold_nx;
  logic [IDXW-1:0] cnt, cnt_nx;
  logic x_nx, valid_nx, done_nx, last, again;
  assign last = (state == SHIFT) && (cnt == IDXW'(WIDTH - 1));
  assign again = last && !STOP && REPEAT;
  assign LOAD_READY = (state == IDLE);
  assign BIT_IDX = cnt;
  assign S = state;
  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    hold_nx = hold;
    cnt_nx = cnt;
    x_nx = x;
    valid_nx = X_VALID;
    done_nx = 1'b0;
    if (state == IDLE) begin
      if (LOAD_VALID) begin
        shreg_nx = DATA;
        hold_nx = DATA;
        x_nx = DATA[0];
        valid_nx = 1'b1;
        cnt_nx = '0;
        state_nx = SHIFT;
      end
    end else if (!last) begin
      shreg_nx = shreg >> 1;
      x_nx = shreg[1];
      cnt_nx = cnt + 1'b1;
    end else if (again) begin
      // Reload from the saved copy so the next pass follows without a gap
      shreg_nx = hold;
      x_nx = hold[0];
      cnt_nx = '0;
      done_nx = 1'b1;
    end else begin
      x_nx = 1'b0;
      valid_nx = 1'b0;
      cnt_nx = '0;
      done_nx = 1'b1;
      state_nx = IDLE;
    end
  end
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      shreg <= '0;
      hold <= '0;
      cnt <= '0;
      x <= 1'b0;
      X_VALID <= 1'b0;
      DONE <= 1'b0;
    end else begin
      state <= state_nx;
      shreg <= shreg_nx;
      hold <= hold_nx;
      cnt <= cnt_nx;
      x <= x_nx;
      X_VALID <= valid_nx;
      DONE <= done_nx;
    end
  end
endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: directed checks of load, shift timing, back-to-back, async reset and repeat/stop.
module tb_serial_pattern_tx;
  logic CLK = 1'b0, RESET, LOAD_VALID, LOAD_READY, STOP, x, X_VALID, DONE;
  logic [19:0] DATA;
  logic [4:0] BIT_IDX;
  logic [1:0] S;
  int tests = 0, fails = 0;
  logic [19:0] pat_a = 20'b10000111010011011011;
  int exp_a[20] = '{1,1,0,1,1,0,1,1,0,0,1,0,1,1,1,0,0,0,0,1};
  serial_pattern_tx #(.WIDTH(20), .IDXW(5)) dut (
    .CLK(CLK), .RESET(RESET), .LOAD_VALID(LOAD_VALID), .LOAD_READY(LOAD_READY),
    .DATA(DATA), .STOP(STOP), .x(x), .X_VALID(X_VALID), .BIT_IDX(BIT_IDX),
    .DONE(DONE), .S(S)
  );
  always #5 CLK = ~CLK;
  // Observed bundle: {x, X_VALID, BIT_IDX, DONE, LOAD_READY, S}
  function automatic logic [10:0] obs();
    return {x, X_VALID, BIT_IDX, DONE, LOAD_READY, S};
  endfunction
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic test_reset();
    RESET = 1'b0; LOAD_VALID = 1'b0; STOP = 1'b0; DATA = '0;
    #3;
    tests++;
    if (obs() !== {1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 2'b00}) begin
      fails++; $display("FAIL reset_held: got %b expected %b", obs(), {1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 2'b00});
    end
    #9 RESET = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      tests++;
      if (obs() !== {1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 2'b00}) begin
        fails++; $display("FAIL reset_idle cycle %0d: got %b expected %b", i, obs(), {1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 2'b00});
      end
    end
  endtask
  task automatic test_pattern();
    DATA = pat_a; LOAD_VALID = 1'b1;
    step();
    LOAD_VALID = 1'b0; DATA = '0;
    for (int i = 0; i < 20; i++) begin
      tests++;
      if (obs() !== {1'(exp_a[i]), 1'b1, 5'(i), 1'b0, 1'b0, 2'b01}) begin
        fails++; $display("FAIL pattern bit %0d: got %b expected %b", i, obs(), {1'(exp_a[i]), 1'b1, 5'(i), 1'b0, 1'b0, 2'b01});
      end
      step();
    end
    tests++;
    if (obs() !== {1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 2'b00}) begin
      fails++; $display("FAIL pattern_done: got %b expected %b", obs(), {1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 2'b00});
    end
    step();
    tests++;
    if (obs() !== {1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 2'b00}) begin
      fails++; $display("FAIL pattern_done_pulse: got %b expected %b", obs(), {1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 2'b00});
    end
  endtask
  task automatic test_back_to_back();
    logic [10:0] e;
    DATA = 20'h00001; LOAD_VALID = 1'b1;
    step();
    DATA = 20'hFFFFF;
    for (int j = 0; j <= 40; j++) begin
      if (j == 20) e = {1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 2'b00};
      else if (j < 20) e = {j == 0, 1'b1, 5'(j), 1'b0, 1'b0, 2'b01};
      else e = {1'b1, 1'b1, 5'(j - 21), 1'b0, 1'b0, 2'b01};
      tests++;
      if (obs() !== e) begin
        fails++; $display("FAIL back_to_back edge k+%0d: got %b expected %b", j, obs(), e);
      end
      if (j == 21) LOAD_VALID = 1'b0;
      step();
    end
    tests++;
    if (obs() !== {1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 2'b00}) begin
      fails++; $display("FAIL back_to_back_done2: got %b expected %b", obs(), {1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 2'b00});
    end
    step();
    tests++;
    if (obs() !== {1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 2'b00}) begin
      fails++; $display("FAIL back_to_back_no_third: got %b expected %b", obs(), {1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 2'b00});
    end
  endtask
  task automatic test_async_reset();
    logic [19:0] d2 = 20'h0000E;
    DATA = pat_a; LOAD_VALID = 1'b1;
    step();
    LOAD_VALID = 1'b0;
    for (int i = 1; i <= 7; i++) step();
    tests++;
    if (obs() !== {1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 2'b01}) begin
      fails++; $display("FAIL async_bit7: got %b expected %b", obs(), {1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 2'b01});
    end
    #2 RESET = 1'b0;
    #1;
    tests++;
    if (obs() !== {1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 2'b00}) begin
      fails++; $display("FAIL async_immediate: got %b expected %b", obs(), {1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 2'b00});
    end
    #4 RESET = 1'b1;
    step();
    tests++;
    if (obs() !== {1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 2'b00}) begin
      fails++; $display("FAIL async_after_release: got %b expected %b", obs(), {1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 2'b00});
    end
    DATA = d2; LOAD_VALID = 1'b1;
    step();
    LOAD_VALID = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tests++;
      if (obs() !== {d2[i], 1'b1, 5'(i), 1'b0, 1'b0, 2'b01}) begin
        fails++; $display("FAIL async_reload bit %0d: got %b expected %b", i, obs(), {d2[i], 1'b1, 5'(i), 1'b0, 1'b0, 2'b01});
      end
      step();
    end
    tests++;
    if (obs() !== {1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 2'b00}) begin
      fails++; $display("FAIL async_reload_done: got %b expected %b", obs(), {1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 2'b00});
    end
    step();
  endtask
  task automatic test_ignore_load();
    DATA = pat_a; LOAD_VALID = 1'b1;
    step();
    LOAD_VALID = 1'b0; DATA = '0;
    for (int i = 0; i < 20; i++) begin
      tests++;
      if (obs() !== {1'(exp_a[i]), 1'b1, 5'(i), 1'b0, 1'b0, 2'b01}) begin
        fails++; $display("FAIL ignore_load bit %0d: got %b expected %b", i, obs(), {1'(exp_a[i]), 1'b1, 5'(i), 1'b0, 1'b0, 2'b01});
      end
      if (i == 5) begin LOAD_VALID = 1'b1; DATA = 20'hFFFFF; end
      if (i == 6) begin LOAD_VALID = 1'b0; DATA = '0; end
      step();
    end
    tests++;
    if (obs() !== {1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 2'b00}) begin
      fails++; $display("FAIL ignore_load_done: got %b expected %b", obs(), {1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 2'b00});
    end
    step();
  endtask
`ifdef PATTERN_REPEAT_EN
  task automatic test_repeat();
    logic [19:0] p = 20'hA5A5A;
    logic [10:0] e;
    DATA = p; LOAD_VALID = 1'b1; STOP = 1'b0;
    step();
    LOAD_VALID = 1'b0;
    for (int j = 0; j < 60; j++) begin
      e = {p[j % 20], 1'b1, 5'(j % 20), (j == 20) || (j == 40), 1'b0, 2'b01};
      tests++;
      if (obs() !== e) begin
        fails++; $display("FAIL repeat edge k+%0d: got %b expected %b", j, obs(), e);
      end
      if (j == 40) STOP = 1'b1;
      step();
    end
    tests++;
    if (obs() !== {1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 2'b00}) begin
      fails++; $display("FAIL repeat_stop_done: got %b expected %b", obs(), {1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 2'b00});
    end
    STOP = 1'b0;
    step();
  endtask
`else
  task automatic test_stop_ignored();
    logic [19:0] p = 20'hA5A5A;
    DATA = p; LOAD_VALID = 1'b1; STOP = 1'b0;
    step();
    LOAD_VALID = 1'b0;
    for (int j = 0; j < 20; j++) begin
      tests++;
      if (obs() !== {p[j], 1'b1, 5'(j), 1'b0, 1'b0, 2'b01}) begin
        fails++; $display("FAIL single_pass bit %0d: got %b expected %b", j, obs(), {p[j], 1'b1, 5'(j), 1'b0, 1'b0, 2'b01});
      end
      step();
    end
    tests++;
    if (obs() !== {1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 2'b00}) begin
      fails++; $display("FAIL single_pass_done: got %b expected %b", obs(), {1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 2'b00});
    end
    step();
  endtask
`endif
  initial begin
    test_reset();
    test_pattern();
    test_back_to_back();
    test_async_reset();
    test_ignore_load();
`ifdef PATTERN_REPEAT_EN
    test_repeat();
`else
    test_stop_ignored();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
